// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus between wb_cmd_master (master side) and a user-area slave.
// Signal names are seen from the master, so _o leaves the master and _i enters it.
interface wb_cmd_master_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_cmd_master.sv
// Single-word Wishbone classic initiator: one command in, one bus cycle, one response out.
// A bus cycle ends on ack or after TIMEOUT_CYCLES cycles without one.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,

  wb_cmd_master_if.master wbm
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          cmd_ready_q;
  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_dat_q;
  logic          rsp_err_q;

  // Ack is only looked at in BUS, so stray acks elsewhere fall through harmlessly.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Ack on the last timeout cycle still counts as a normal completion.
          if (wbm.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? 32'd0 : wbm.wbm_dat_i;
            state_q     <= ST_RESP;
          end else if (timer_q == TIMER_LAST) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= 32'd0;
            state_q     <= ST_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: scripted commands against a programmable-latency slave,
// expected responses queued on issue and compared when the response appears.
module tb_wb_cmd_master;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  wb_cmd_master_if wbm_if ();

  wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm         (wbm_if)
  );

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: acks after wait_states cycles of cyc, or never when slave_en=0.
  logic        slave_en    = 1'b0;
  int          wait_states = 0;
  int          wcnt        = 0;
  logic        slv_ack     = 1'b0;
  logic        spur_ack    = 1'b0;
  logic [31:0] rd_data     = 32'h0;

  assign wbm_if.wbm_ack_i = slv_ack | spur_ack;
  assign wbm_if.wbm_dat_i = rd_data;

  always @(negedge clk) begin
    if (wbm_if.wbm_cyc_o && slave_en) begin
      slv_ack = (wcnt == wait_states);
      wcnt++;
    end else begin
      slv_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Bus monitor: counts cyc-high cycles and checks the bus against the issued command.
  int          cyc_hi = 0;
  logic        exp_we;
  logic [31:0] exp_adr;
  logic [31:0] exp_dat;
  logic [3:0]  exp_sel;

  always @(negedge clk) begin
    check("cyc_eq_stb", 32'(wbm_if.wbm_stb_o), 32'(wbm_if.wbm_cyc_o));
    if (rst_n && wbm_if.wbm_cyc_o) begin
      cyc_hi++;
      check("bus_we",  32'(wbm_if.wbm_we_o),  32'(exp_we));
      check("bus_adr", wbm_if.wbm_adr_o,      exp_adr);
      check("bus_dat", wbm_if.wbm_dat_o,      exp_dat);
      check("bus_sel", 32'(wbm_if.wbm_sel_o), 32'(exp_sel));
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] e_dat, input logic e_err);
    int n;
    rsp_t r;
    r.dat = e_dat;
    r.err = e_err;
    sb.push_back(r);
    exp_we  = we;
    exp_adr = adr;
    exp_dat = dat;
    exp_sel = sel;
    cyc_hi  = 0;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr   = 32'h0BAD_0BAD;
    cmd_dat   = 32'h0BAD_0BAD;
    check("cyc_after_cmd", 32'(wbm_if.wbm_cyc_o), 32'd1);
    check("ready_in_bus", 32'(cmd_ready), 32'd0);
  endtask

  task automatic recv_rsp(input int hold, input logic spur, input int exp_cyc);
    int n;
    logic [31:0] d0;
    logic        e0;
    rsp_t        r;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check("cyc_low_in_resp", 32'(wbm_if.wbm_cyc_o), 32'd0);
    d0 = rsp_dat;
    e0 = rsp_err;
    spur_ack = spur;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_dat", rsp_dat, d0);
      check("hold_err", 32'(rsp_err), 32'(e0));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    end
    spur_ack = 1'b0;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check("rsp_dat", d0, r.dat);
      check("rsp_err", 32'(e0), 32'(r.err));
    end
    check("cyc_cycles", 32'(cyc_hi), 32'(exp_cyc));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rw;
    int          ws;
    logic [31:0] a, d, rd;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    check("rst_we", 32'(wbm_if.wbm_we_o), 32'd0);
    check("rst_adr", wbm_if.wbm_adr_o, 32'd0);
    check("rst_dat", wbm_if.wbm_dat_o, 32'd0);
    check("rst_sel", 32'(wbm_if.wbm_sel_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write, zero-wait slave; read data on the bus must not leak into the response.
    slave_en = 1'b1; wait_states = 0; rd_data = 32'hA5A5_A5A5;
    send_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    recv_rsp(0, 1'b0, 1);

    // Read with three wait states.
    wait_states = 3; rd_data = 32'h1234_5678;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    recv_rsp(0, 1'b0, 4);

    // Timeout with no ack.
    slave_en = 1'b0; rd_data = 32'h5555_AAAA;
    send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3, 32'h0, 1'b1);
    recv_rsp(0, 1'b0, TO);

    // Ack on the final timeout cycle wins.
    slave_en = 1'b1; wait_states = TO - 1; rd_data = 32'hCAFE_F00D;
    send_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hC, 32'hCAFE_F00D, 1'b0);
    recv_rsp(0, 1'b0, TO);

    // Backpressure on the response port.
    wait_states = 0; rd_data = 32'h0F0F_1E1E;
    send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'h0F0F_1E1E, 1'b0);
    recv_rsp(5, 1'b0, 1);

    // Next command accepted right after the response handshake.
    send_cmd(1'b1, 32'h3000_0034, 32'h7777_8888, 4'h1, 32'h0, 1'b0);
    recv_rsp(0, 1'b0, 1);

    // Spurious ack in IDLE.
    spur_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_idle_rsp", 32'(rsp_valid), 32'd0);
      check("spur_idle_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
      check("spur_idle_ready", 32'(cmd_ready), 32'd1);
    end
    spur_ack = 1'b0;

    // Spurious ack while parked in RESP.
    wait_states = 1; rd_data = 32'h2468_ACE0;
    send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'h2468_ACE0, 1'b0);
    recv_rsp(3, 1'b1, 2);
    repeat (2) begin
      @(negedge clk);
      check("no_extra_rsp", 32'(rsp_valid), 32'd0);
    end

    // Reset asserted between edges during BUS.
    slave_en = 1'b0;
    send_cmd(1'b1, 32'h3000_0050, 32'h1111_2222, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wbm_if.wbm_stb_o), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_adr", wbm_if.wbm_adr_o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_cyc", 32'(wbm_if.wbm_cyc_o), 32'd0);
    slave_en = 1'b1; wait_states = 2; rd_data = 32'h9ABC_DEF0;
    send_cmd(1'b0, 32'h3000_0060, 32'h0, 4'hF, 32'h9ABC_DEF0, 1'b0);
    recv_rsp(0, 1'b0, 3);

    // Mixed random traffic.
    for (int k = 0; k < 6; k++) begin
      rw = 1'($urandom_range(0, 1));
      ws = int'($urandom_range(0, 3));
      a  = $urandom();
      d  = $urandom();
      rd = $urandom();
      wait_states = ws;
      rd_data     = rd;
      send_cmd(rw, a, d, 4'($urandom_range(0, 15)), rw ? 32'h0 : rd, 1'b0);
      recv_rsp(int'($urandom_range(0, 2)), 1'b0, ws + 1);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
